tri_receiver: RTL and testbench



---
 rtl/graphics_pkg.sv | 15 +
 rtl/tri_fifo.sv | 60 ++++++
 rtl/tri_receiver.sv | 129 ++++++++++++
 tb/tb_tri_receiver.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/graphics_pkg.sv
// Shared graphics-pipeline types: vertex/triangle payloads and the
// triangle-id sequence checker state.
package graphics_pkg;

    typedef logic [2:0][15:0]      vertex_t;
    typedef logic [2:0][2:0][15:0] tri_verts_t;

    localparam int unsigned VERTS_BITS = 144;

    typedef enum logic {
        EXPECT_FIRST,
        IN_FRAME
    } chk_state_t;

endpackage

// File: rtl/tri_fifo.sv
// Synchronous FIFO with registered storage and combinational head data.
// Pushes are refused while full (even if a pop happens the same cycle);
// pops are ignored while empty.
module tri_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_data
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Storage, pointers and occupancy; reset clears storage so head data reads 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/tri_receiver.sv
// Triangle-stream receiver: buffers triangles from the fetch stage,
// re-presents them downstream, checks per-frame id sequencing on the push
// side and counts delivered triangles per frame on the pop side.
module tri_receiver
    import graphics_pkg::*;
#(
    parameter  int unsigned TRI_COUNT    = 2048,
    parameter  int unsigned FIFO_DEPTH   = 4,
    localparam int unsigned TRI_ID_WIDTH = $clog2(TRI_COUNT),
    localparam int unsigned CNT_WIDTH    = $clog2(TRI_COUNT + 1)
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  tri_verts_t              tri_vertices_in,
    input  logic [TRI_ID_WIDTH-1:0] tri_id_in,
    input  logic                    last_tri_in,
    output logic                    valid_out,
    input  logic                    ready_in,
    output tri_verts_t              tri_vertices_out,
    output logic [TRI_ID_WIDTH-1:0] tri_id_out,
    output logic                    last_tri_out,
    output logic                    frame_done_out,
    output logic [CNT_WIDTH-1:0]    tri_count_out,
    output logic                    seq_error_out,
    output logic                    err_sticky_out
);

    localparam int unsigned ENTRY_W = VERTS_BITS + TRI_ID_WIDTH + 1;
    localparam logic [TRI_ID_WIDTH-1:0] LAST_ID = TRI_ID_WIDTH'(TRI_COUNT - 1);

    logic [ENTRY_W-1:0]      w_fifo_in;
    logic [ENTRY_W-1:0]      w_head;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic [TRI_ID_WIDTH-1:0] w_expected;
    logic                    w_violation;

    chk_state_t              r_state;
    logic [TRI_ID_WIDTH-1:0] r_expected_id;
    logic                    r_seq_error;
    logic                    r_err_sticky;
    logic [CNT_WIDTH-1:0]    r_delivered;
    logic [CNT_WIDTH-1:0]    r_tri_count;
    logic                    r_frame_done;

    assign ready_out = !w_full && !rst_in;
    assign valid_out = !w_empty;
    assign w_push    = valid_in && ready_out;
    assign w_pop     = valid_out && ready_in;

    assign w_fifo_in        = {tri_vertices_in, tri_id_in, last_tri_in};
    assign tri_vertices_out = w_head[ENTRY_W-1 -: VERTS_BITS];
    assign tri_id_out       = w_head[TRI_ID_WIDTH:1];
    assign last_tri_out     = w_head[0];

    tri_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_in),
        .i_rst   (rst_in),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_fifo_in),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_data  (w_head)
    );

    // The first triangle of a frame must carry id 0; only the final id may be flagged last.
    assign w_expected  = (r_state == EXPECT_FIRST) ? '0 : r_expected_id;
    assign w_violation = (tri_id_in != w_expected) ||
                         (last_tri_in != (tri_id_in == LAST_ID));

    // Push-side sequence checker; resyncs to the received id after an error.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state       <= EXPECT_FIRST;
            r_expected_id <= '0;
            r_seq_error   <= 1'b0;
            r_err_sticky  <= 1'b0;
        end else begin
            r_seq_error <= 1'b0;
            if (w_push) begin
                r_seq_error <= w_violation;
                if (w_violation) begin
                    r_err_sticky <= 1'b1;
                end
                if (last_tri_in) begin
                    r_state       <= EXPECT_FIRST;
                    r_expected_id <= '0;
                end else begin
                    r_state       <= IN_FRAME;
                    r_expected_id <= tri_id_in + TRI_ID_WIDTH'(1);
                end
            end
        end
    end

    // Pop-side frame counter; publishes the count when the last triangle leaves.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_delivered  <= '0;
            r_tri_count  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_pop) begin
                if (last_tri_out) begin
                    r_tri_count  <= r_delivered + CNT_WIDTH'(1);
                    r_delivered  <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_delivered <= r_delivered + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign seq_error_out  = r_seq_error;
    assign err_sticky_out = r_err_sticky;
    assign frame_done_out = r_frame_done;
    assign tri_count_out  = r_tri_count;

endmodule

// File: tb/tb_tri_receiver.sv
// Directed self-checking bench for tri_receiver with TRI_COUNT=8, FIFO_DEPTH=4.
module tb_tri_receiver;
    import graphics_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    logic       ready_out;
    tri_verts_t verts_in = '0;
    logic [2:0] id_in = '0;
    logic       last_in = 1'b0;
    logic       valid_out;
    logic       ready_in = 1'b0;
    tri_verts_t verts_out;
    logic [2:0] id_out;
    logic       last_out;
    logic       frame_done;
    logic [3:0] tri_count;
    logic       seq_error;
    logic       err_sticky;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tri_receiver #(
        .TRI_COUNT  (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .valid_in         (valid_in),
        .ready_out        (ready_out),
        .tri_vertices_in  (verts_in),
        .tri_id_in        (id_in),
        .last_tri_in      (last_in),
        .valid_out        (valid_out),
        .ready_in         (ready_in),
        .tri_vertices_out (verts_out),
        .tri_id_out       (id_out),
        .last_tri_out     (last_out),
        .frame_done_out   (frame_done),
        .tri_count_out    (tri_count),
        .seq_error_out    (seq_error),
        .err_sticky_out   (err_sticky)
    );

    typedef struct {
        logic       v;
        logic [2:0] id;
        logic       last;
        logic       rdy;
        logic       e_rdyout;
        logic       e_vout;
        logic [2:0] e_id;
        logic       e_err;
        logic       e_sticky;
        logic       e_done;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic v, logic [2:0] id, logic last, logic rdy,
                                logic e_rdyout, logic e_vout, logic [2:0] e_id,
                                logic e_err, logic e_sticky, logic e_done, logic [3:0] e_cnt);
        vec_t r;
        r.v = v; r.id = id; r.last = last; r.rdy = rdy;
        r.e_rdyout = e_rdyout; r.e_vout = e_vout; r.e_id = e_id;
        r.e_err = e_err; r.e_sticky = e_sticky; r.e_done = e_done; r.e_cnt = e_cnt;
        tbl.push_back(r);
    endfunction

    function automatic tri_verts_t verts_of(logic [2:0] id);
        tri_verts_t t;
        for (int a = 0; a < 3; a++)
            for (int c = 0; c < 3; c++)
                t[a][c] = 16'h1000 + 16'(id) * 16'd16 + 16'(a * 4 + c);
        return t;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, and settle just after the edge.
    task automatic step(logic v, logic [2:0] id, logic last, logic rdy);
        valid_in = v;
        id_in    = id;
        last_in  = last;
        verts_in = verts_of(id);
        ready_in = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_head(string tag, logic [2:0] eid);
        check({tag, " valid_out"}, 32'(valid_out), 32'd1);
        check({tag, " id_out"}, 32'(id_out), 32'(eid));
        check({tag, " verts_out"}, 32'(verts_out == verts_of(eid)), 32'd1);
    endtask

    initial begin
        // Frame A: clean 0..7; frame B: 0,1,3..7 (skip); frame C: last on 5; D: id 0.
        add(1,0,0,1, 1,1,0, 0,0,0,0);
        add(1,1,0,1, 1,1,1, 0,0,0,0);
        add(1,2,0,1, 1,1,2, 0,0,0,0);
        add(1,3,0,1, 1,1,3, 0,0,0,0);
        add(1,4,0,1, 1,1,4, 0,0,0,0);
        add(1,5,0,1, 1,1,5, 0,0,0,0);
        add(1,6,0,1, 1,1,6, 0,0,0,0);
        add(1,7,1,1, 1,1,7, 0,0,0,0);
        add(1,0,0,1, 1,1,0, 0,0,1,8);
        add(1,1,0,1, 1,1,1, 0,0,0,8);
        add(1,3,0,1, 1,1,3, 1,1,0,8);
        add(1,4,0,1, 1,1,4, 0,1,0,8);
        add(1,5,0,1, 1,1,5, 0,1,0,8);
        add(1,6,0,1, 1,1,6, 0,1,0,8);
        add(1,7,1,1, 1,1,7, 0,1,0,8);
        add(1,0,0,1, 1,1,0, 0,1,1,7);
        add(1,1,0,1, 1,1,1, 0,1,0,7);
        add(1,2,0,1, 1,1,2, 0,1,0,7);
        add(1,3,0,1, 1,1,3, 0,1,0,7);
        add(1,4,0,1, 1,1,4, 0,1,0,7);
        add(1,5,1,1, 1,1,5, 1,1,0,7);
        add(1,0,0,1, 1,1,0, 0,1,1,6);
        add(0,0,0,1, 1,0,0, 0,1,0,6);

        // Reset state.
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst ready_out", 32'(ready_out), 32'd0);
        check("rst valid_out", 32'(valid_out), 32'd0);
        check("rst id_out", 32'(id_out), 32'd0);
        check("rst last_out", 32'(last_out), 32'd0);
        check("rst verts_out", 32'(verts_out == '0), 32'd1);
        check("rst frame_done", 32'(frame_done), 32'd0);
        check("rst tri_count", 32'(tri_count), 32'd0);
        check("rst seq_error", 32'(seq_error), 32'd0);
        check("rst err_sticky", 32'(err_sticky), 32'd0);
        rst = 1'b0;
        #1;
        check("post-rst ready_out", 32'(ready_out), 32'd1);

        // Table-driven streaming and sequencing checks.
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].id, tbl[i].last, tbl[i].rdy);
            check($sformatf("row%0d ready_out", i), 32'(ready_out), 32'(tbl[i].e_rdyout));
            check($sformatf("row%0d valid_out", i), 32'(valid_out), 32'(tbl[i].e_vout));
            if (tbl[i].e_vout) begin
                check($sformatf("row%0d id_out", i), 32'(id_out), 32'(tbl[i].e_id));
                check($sformatf("row%0d verts_out", i), 32'(verts_out == verts_of(tbl[i].e_id)), 32'd1);
            end
            check($sformatf("row%0d seq_error", i), 32'(seq_error), 32'(tbl[i].e_err));
            check($sformatf("row%0d err_sticky", i), 32'(err_sticky), 32'(tbl[i].e_sticky));
            check($sformatf("row%0d frame_done", i), 32'(frame_done), 32'(tbl[i].e_done));
            check($sformatf("row%0d tri_count", i), 32'(tri_count), 32'(tbl[i].e_cnt));
        end

        // Backpressure: fill to depth, hold id 4 off, then full-with-pop refusal.
        do_reset();
        check("bp sticky cleared", 32'(err_sticky), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 3'(k), 1'b0, 1'b0);
            chk_head($sformatf("bp fill%0d", k), 3'd0);
            check($sformatf("bp fill%0d ready_out", k), 32'(ready_out), (k == 3) ? 32'd0 : 32'd1);
        end
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 3'd4, 1'b0, 1'b0);
            chk_head($sformatf("bp hold%0d", k), 3'd0);
            check($sformatf("bp hold%0d ready_out", k), 32'(ready_out), 32'd0);
        end
        step(1'b1, 3'd4, 1'b0, 1'b1);
        chk_head("bp full-pop", 3'd1);
        check("bp full-pop ready_out", 32'(ready_out), 32'd1);
        step(1'b1, 3'd4, 1'b0, 1'b1);
        chk_head("bp push4", 3'd2);
        step(1'b0, 3'd0, 1'b0, 1'b1);
        chk_head("bp drain3", 3'd3);
        step(1'b0, 3'd0, 1'b0, 1'b1);
        chk_head("bp drain4", 3'd4);
        step(1'b0, 3'd0, 1'b0, 1'b1);
        check("bp empty valid_out", 32'(valid_out), 32'd0);
        check("bp no error", 32'(err_sticky), 32'd0);

        // Mid-frame reset after id 3, then a clean frame.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 3'(k), 1'b0, 1'b1);
            chk_head($sformatf("mr pre%0d", k), 3'(k));
        end
        rst = 1'b1;
        step(1'b0, 3'd0, 1'b0, 1'b1);
        check("mr valid_out", 32'(valid_out), 32'd0);
        check("mr ready_out in reset", 32'(ready_out), 32'd0);
        check("mr id_out", 32'(id_out), 32'd0);
        rst = 1'b0;
        #1;
        check("mr ready_out after", 32'(ready_out), 32'd1);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 3'(k), k == 7, 1'b1);
            chk_head($sformatf("mr frame%0d", k), 3'(k));
            check($sformatf("mr frame%0d seq_error", k), 32'(seq_error), 32'd0);
            check($sformatf("mr frame%0d frame_done", k), 32'(frame_done), 32'd0);
        end
        step(1'b0, 3'd0, 1'b0, 1'b1);
        check("mr frame_done", 32'(frame_done), 32'd1);
        check("mr tri_count", 32'(tri_count), 32'd8);
        check("mr err_sticky", 32'(err_sticky), 32'd0);
        step(1'b0, 3'd0, 1'b0, 1'b1);
        check("mr frame_done pulse", 32'(frame_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
